// File: rtl/scb_vector_monitor_pkg.sv
// Shared types and helpers for the vector-change monitor.
package scb_vector_monitor_pkg;

  localparam int C_WIDTH   = 30;
  localparam int C_TS_BITS = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } t_mon_state;

  typedef struct packed {
    logic [C_TS_BITS-1:0] ts;
    logic [C_WIDTH-1:0]   vec;
  } t_mon_event;

  function automatic int f_log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/scb_vector_monitor_if.sv
// Capture/drain bus between the monitor and whoever consumes its events.
interface scb_vector_monitor_if
  import scb_vector_monitor_pkg::*;
#(
  parameter int g_width      = 30,
  parameter int g_ts_bits    = 16,
  parameter int g_fifo_depth = 8,
  parameter int g_drop_bits  = 8
);
  logic [g_width-1:0]            vector_i;
  logic                          enable_i;
  logic                          rd_i;
  logic                          clear_i;
  logic                          valid_o;
  logic [g_width-1:0]            vec_o;
  logic [g_ts_bits-1:0]          ts_o;
  logic [f_log2(g_fifo_depth):0] count_o;
  logic                          overflow_o;
  logic [g_drop_bits-1:0]        dropped_o;

  modport master (
    output vector_i, enable_i, rd_i, clear_i,
    input  valid_o, vec_o, ts_o, count_o, overflow_o, dropped_o
  );

  modport slave (
    input  vector_i, enable_i, rd_i, clear_i,
    output valid_o, vec_o, ts_o, count_o, overflow_o, dropped_o
  );
endinterface

// File: rtl/scb_mon_fifo.sv
// Generic first-word-fall-through FIFO; a write into a full FIFO succeeds
// when a read happens in the same cycle.
module scb_mon_fifo
  import scb_vector_monitor_pkg::*;
#(
  parameter int g_depth = 8,
  parameter int g_dw    = 46
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr,
  input  logic [g_dw-1:0]           i_wdata,
  input  logic                      i_rd,
  output logic [g_dw-1:0]           o_rdata,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [f_log2(g_depth):0]  o_count
);
  localparam int AW = f_log2(g_depth);
  localparam logic [AW:0] LP_FULL = (AW+1)'(g_depth);

  logic [g_dw-1:0] r_mem [g_depth];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_count;
  logic            w_rd, w_wr;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == LP_FULL);
  assign w_rd    = i_rd & ~o_empty;
  assign w_wr    = i_wr & (~o_full | w_rd);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < g_depth; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (w_rd && !w_wr) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/scb_vector_monitor.sv
// Watches a vector, queues {timestamp, vector} on every change, and counts
// events lost to a full FIFO.
module scb_vector_monitor
  import scb_vector_monitor_pkg::*;
#(
  parameter int g_width      = 30,
  parameter int g_ts_bits    = 16,
  parameter int g_fifo_depth = 8,
  parameter int g_drop_bits  = 8
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_sys_i,
  scb_vector_monitor_if.slave   bus
);
  localparam int DW = g_width + g_ts_bits;

  t_mon_state             r_state, w_next;
  logic [g_ts_bits-1:0]   r_ts;
  logic [g_width-1:0]     r_prev;
  logic                   r_overflow;
  logic [g_drop_bits-1:0] r_dropped;
  logic                   w_push, w_drop, w_empty, w_full;
  logic [DW-1:0]          w_head;

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      S_IDLE:  if (bus.enable_i) w_next = S_PRIME;
      S_PRIME: begin
        w_push = 1'b1;
        w_next = bus.enable_i ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (!bus.enable_i)               w_next = S_IDLE;
        else if (bus.vector_i != r_prev) w_push = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A full FIFO only drops when no pop frees a slot in the same cycle.
  assign w_drop = w_push & w_full & ~bus.rd_i;

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      r_state    <= S_IDLE;
      r_ts       <= '0;
      r_prev     <= '0;
      r_overflow <= 1'b0;
      r_dropped  <= '0;
    end else begin
      r_state <= w_next;
      r_ts    <= r_ts + 1'b1;
      if (r_state == S_PRIME || r_state == S_RUN) r_prev <= bus.vector_i;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (bus.clear_i)           r_dropped <= {{(g_drop_bits-1){1'b0}}, 1'b1};
        else if (r_dropped != '1)  r_dropped <= r_dropped + 1'b1;
      end else if (bus.clear_i) begin
        r_overflow <= 1'b0;
        r_dropped  <= '0;
      end
    end
  end

  scb_mon_fifo #(
    .g_depth (g_fifo_depth),
    .g_dw    (DW)
  ) u_fifo (
    .i_clk   (clk_sys_i),
    .i_rst   (rst_sys_i),
    .i_wr    (w_push),
    .i_wdata ({r_ts, bus.vector_i}),
    .i_rd    (bus.rd_i),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (bus.count_o)
  );

  assign bus.valid_o    = ~w_empty;
  assign bus.vec_o      = w_empty ? '0 : w_head[g_width-1:0];
  assign bus.ts_o       = w_empty ? '0 : w_head[DW-1:g_width];
  assign bus.overflow_o = r_overflow;
  assign bus.dropped_o  = r_dropped;
endmodule

// File: tb/tb_scb_vector_monitor.sv
// Directed bench for the vector-change monitor.
module tb_scb_vector_monitor;
  import scb_vector_monitor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  t_mon_event head;

  always #5 clk = ~clk;

  scb_vector_monitor_if #(.g_width(30), .g_ts_bits(16), .g_fifo_depth(8), .g_drop_bits(8)) bus();

  scb_vector_monitor #(.g_width(30), .g_ts_bits(16), .g_fifo_depth(8), .g_drop_bits(8)) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .bus       (bus)
  );

  assign head = {bus.ts_o, bus.vec_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop();
    bus.rd_i = 1'b1;
    tick();
    bus.rd_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.vector_i = '0; bus.enable_i = 1'b0; bus.rd_i = 1'b0; bus.clear_i = 1'b0;
    rst = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.valid_o, bus.vec_o, bus.ts_o, bus.count_o, bus.overflow_o, bus.dropped_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got valid=%0b vec=%0h ts=%0h cnt=%0d ovf=%0b drop=%0d, want all 0",
               bus.valid_o, bus.vec_o, bus.ts_o, bus.count_o, bus.overflow_o, bus.dropped_o);
    end
    rst = 1'b0;
    bus.enable_i = 1'b1;
  endtask

  task automatic test_baseline();
    tick();
    n_cmp++;
    if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL prime_no_push: count=%0d want 0", bus.count_o); end
    tick();
    n_cmp++;
    if (bus.count_o !== 4'd1 || bus.valid_o !== 1'b1) begin
      n_bad++; $display("FAIL baseline_count: count=%0d valid=%0b want 1/1", bus.count_o, bus.valid_o);
    end
    n_cmp++;
    if (head.vec !== 30'd0 || head.ts !== 16'd1) begin
      n_bad++; $display("FAIL baseline_entry: vec=%0d ts=%0d want 0/1", head.vec, head.ts);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (bus.count_o !== 4'd1) begin n_bad++; $display("FAIL constant_vec: cycle %0d count=%0d want 1", i, bus.count_o); end
    end
  endtask

  task automatic test_sequence();
    tick();
    bus.vector_i = 30'd1;
    tick();
    n_cmp++;
    if (bus.count_o !== 4'd2) begin n_bad++; $display("FAIL change1_count: count=%0d want 2", bus.count_o); end
    repeat (29) tick();
    bus.vector_i = 30'd10;
    tick();
    n_cmp++;
    if (bus.count_o !== 4'd3) begin n_bad++; $display("FAIL change2_count: count=%0d want 3", bus.count_o); end
    n_cmp++;
    if (head.vec !== 30'd0 || head.ts !== 16'd1) begin n_bad++; $display("FAIL seq_head0: vec=%0d ts=%0d want 0/1", head.vec, head.ts); end
    pop();
    n_cmp++;
    if (head.vec !== 30'd1 || head.ts !== 16'd23) begin n_bad++; $display("FAIL seq_head1: vec=%0d ts=%0d want 1/23", head.vec, head.ts); end
    pop();
    n_cmp++;
    if (head.vec !== 30'd10 || head.ts !== 16'd53) begin n_bad++; $display("FAIL seq_head2: vec=%0d ts=%0d want 10/53", head.vec, head.ts); end
    pop();
    n_cmp++;
    if (bus.valid_o !== 1'b0 || bus.count_o !== 4'd0) begin
      n_bad++; $display("FAIL seq_drained: valid=%0b count=%0d want 0/0", bus.valid_o, bus.count_o);
    end
    pop();
    n_cmp++;
    if (bus.count_o !== 4'd0 || bus.vec_o !== 30'd0) begin
      n_bad++; $display("FAIL rd_empty: count=%0d vec=%0d want 0/0", bus.count_o, bus.vec_o);
    end
  endtask

  task automatic test_overflow();
    bus.enable_i = 1'b0;
    tick();
    bus.vector_i = 30'd0;
    bus.enable_i = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus.count_o !== 4'd1) begin n_bad++; $display("FAIL ovf_baseline: count=%0d want 1", bus.count_o); end
    for (int i = 0; i < 12; i++) begin
      bus.vector_i = (i % 2 == 0) ? 30'd1 : 30'd0;
      tick();
    end
    n_cmp++;
    if (bus.count_o !== 4'd8 || bus.overflow_o !== 1'b1 || bus.dropped_o !== 8'd5) begin
      n_bad++; $display("FAIL ovf_state: count=%0d ovf=%0b drop=%0d want 8/1/5", bus.count_o, bus.overflow_o, bus.dropped_o);
    end
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    n_cmp++;
    if (bus.overflow_o !== 1'b0 || bus.dropped_o !== 8'd0) begin
      n_bad++; $display("FAIL clear: ovf=%0b drop=%0d want 0/0", bus.overflow_o, bus.dropped_o);
    end
    n_cmp++;
    if (bus.count_o !== 4'd8 || head.vec !== 30'd0) begin
      n_bad++; $display("FAIL clear_keeps: count=%0d vec=%0d want 8/0", bus.count_o, head.vec);
    end
  endtask

  task automatic test_full_rd();
    bus.vector_i = 30'd1;
    pop();
    n_cmp++;
    if (bus.count_o !== 4'd8 || bus.overflow_o !== 1'b0 || bus.dropped_o !== 8'd0) begin
      n_bad++; $display("FAIL full_rd: count=%0d ovf=%0b drop=%0d want 8/0/0", bus.count_o, bus.overflow_o, bus.dropped_o);
    end
    n_cmp++;
    if (head.vec !== 30'd1) begin n_bad++; $display("FAIL full_rd_head: vec=%0d want 1", head.vec); end
    repeat (7) pop();
    n_cmp++;
    if (bus.count_o !== 4'd1 || head.vec !== 30'd1) begin
      n_bad++; $display("FAIL full_rd_tail: count=%0d vec=%0d want 1/1", bus.count_o, head.vec);
    end
  endtask

  task automatic test_enable_low();
    pop();
    bus.enable_i = 1'b0;
    tick();
    bus.vector_i = 30'd5; tick();
    bus.vector_i = 30'd6; tick();
    n_cmp++;
    if (bus.count_o !== 4'd0 || bus.valid_o !== 1'b0) begin
      n_bad++; $display("FAIL disabled: count=%0d valid=%0b want 0/0", bus.count_o, bus.valid_o);
    end
    bus.enable_i = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus.count_o !== 4'd1 || head.vec !== 30'd6) begin
      n_bad++; $display("FAIL reenable: count=%0d vec=%0d want 1/6", bus.count_o, head.vec);
    end
  endtask

  task automatic test_reset_midrun();
    bus.vector_i = 30'd7; tick();
    bus.vector_i = 30'd8; tick();
    bus.vector_i = 30'd9; tick();
    n_cmp++;
    if (bus.count_o !== 4'd4) begin n_bad++; $display("FAIL pre_reset: count=%0d want 4", bus.count_o); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.valid_o, bus.vec_o, bus.ts_o, bus.count_o, bus.overflow_o, bus.dropped_o} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: valid=%0b vec=%0h ts=%0h cnt=%0d ovf=%0b drop=%0d want all 0",
               bus.valid_o, bus.vec_o, bus.ts_o, bus.count_o, bus.overflow_o, bus.dropped_o);
    end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (bus.count_o !== 4'd0) begin n_bad++; $display("FAIL post_reset_idle: count=%0d want 0", bus.count_o); end
    tick();
    n_cmp++;
    if (bus.count_o !== 4'd1 || head.vec !== 30'd9 || head.ts !== 16'd1) begin
      n_bad++; $display("FAIL post_reset_base: count=%0d vec=%0d ts=%0d want 1/9/1", bus.count_o, head.vec, head.ts);
    end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_sequence();
    test_overflow();
    test_full_rd();
    test_enable_low();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
